// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first A - B through one generate/propagate full-adder cell (B inverted, carry preset to 1).
// Latency WIDTH+1 cycles per op; start is accepted only in IDLE or DONE, ignored while busy.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-2:0] acc_q,    acc_d;
    logic             c_q,      c_d;
    logic             c_msb_q,  c_msb_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q,    ovf_d;
    logic             zero_q,   zero_d;

    logic             x, y, p, g, s, c_nxt, last;
    logic [WIDTH-1:0] sum_w;

    // One full-adder cell; the subtrahend bit is inverted on its way in.
    assign x     = a_sh_q[0];
    assign y     = ~b_sh_q[0];
    assign p     = x ^ y;
    assign g     = x & y;
    assign s     = p ^ c_q;
    assign c_nxt = g | (p & c_q);
    assign last  = (cnt_q == CNT_W'(WIDTH - 1));

    // The oldest sum bit would fall out anyway, so acc keeps only WIDTH-1 bits;
    // on the final cycle the new sum bit completes the full-width result.
    assign sum_w = {s, acc_q};

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        acc_d    = acc_q;
        c_d      = c_q;
        c_msb_d  = c_msb_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    c_d     = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                acc_d  = sum_w[WIDTH-1:1];
                c_d    = c_nxt;
                cnt_d  = cnt_q + 1'b1;
                if (last) begin
                    c_msb_d  = c_q;
                    diff_d   = sum_w;
                    borrow_d = ~c_nxt;
                    ovf_d    = c_msb_d ^ c_nxt;
                    zero_d   = (sum_w == '0);
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_q    <= '0;
            c_q      <= 1'b0;
            c_msb_q  <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            acc_q    <= acc_d;
            c_q      <= c_d;
            c_msb_q  <= c_msb_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed checks of serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, borrow, ovf, zero;
    logic [W-1:0] diff;

    int n_checks = 0;
    int n_fail   = 0;

    // Last completed result, expected to hold until the next done.
    logic [W-1:0] hold_diff;
    logic         hold_borrow, hold_ovf, hold_zero;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: integer subtraction and sign rules, no bit-level carry chain.
    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv,
                         output logic [W-1:0] d, output logic br,
                         output logic ov, output logic z);
        int sa, sb, sd;
        d  = W'(int'(av) - int'(bv));
        br = (av < bv);
        sa = av[W-1] ? int'(av) - (1 << W) : int'(av);
        sb = bv[W-1] ? int'(bv) - (1 << W) : int'(bv);
        sd = sa - sb;
        ov = (sd > (1 << (W-1)) - 1) || (sd < -(1 << (W-1)));
        z  = (d == '0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [W-1:0] d;
        logic br, ov, z;
        model(av, bv, d, br, ov, z);
        check({tag, ".diff"},   32'(diff),   32'(d));
        check({tag, ".borrow"}, 32'(borrow), 32'(br));
        check({tag, ".ovf"},    32'(ovf),    32'(ov));
        check({tag, ".zero"},   32'(zero),   32'(z));
        hold_diff = d; hold_borrow = br; hold_ovf = ov; hold_zero = z;
    endtask

    // One complete operation from IDLE; optional stray start pulse in the middle of RUN.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input bit mid_start);
        start = 1'b1; a = av; b = bv;
        tick();
        start = 1'b0; a = W'($urandom); b = W'($urandom);
        for (int i = 0; i < W; i++) begin
            check({tag, ".busy"}, 32'(busy), 32'd1);
            check({tag, ".done_lo"}, 32'(done), 32'd0);
            check({tag, ".hold_diff"}, 32'(diff), 32'(hold_diff));
            check({tag, ".hold_zero"}, 32'(zero), 32'(hold_zero));
            if (mid_start && i == 3) begin
                start = 1'b1; a = W'($urandom); b = W'($urandom);
            end else begin
                start = 1'b0;
            end
            if (i < W - 1) tick();
        end
        tick();
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".busy_lo"}, 32'(busy), 32'd0);
        check_result(tag, av, bv);
        tick();
        check({tag, ".done_drop"}, 32'(done), 32'd0);
        check({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [W-1:0] pa, pb;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        hold_diff = '0; hold_borrow = 1'b0; hold_ovf = 1'b0; hold_zero = 1'b0;
        tick(); tick();
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.diff", 32'(diff), 32'd0);
        check("rst.flags", {29'd0, borrow, ovf, zero}, 32'd0);

        // Reset wins over a simultaneous start.
        start = 1'b1; a = 8'h12; b = 8'h34;
        tick();
        check("rst_start.busy", 32'(busy), 32'd0);
        start = 1'b0; rst_n = 1'b1;
        tick();

        run_op("d05_03", 8'h05, 8'h03, 1'b0);
        run_op("d03_05", 8'h03, 8'h05, 1'b0);
        run_op("d80_01", 8'h80, 8'h01, 1'b0);
        run_op("d7f_ff", 8'h7F, 8'hFF, 1'b0);
        run_op("d5a_5a", 8'h5A, 8'h5A, 1'b0);
        run_op("hold_zero", 8'h11, 8'h22, 1'b0);
        run_op("mid_start", 8'hC3, 8'h3C, 1'b1);

        for (int n = 0; n < 30; n++)
            run_op("rand", W'($urandom), W'($urandom), n[0]);

        // start held high, operands changing every cycle: only accepting edges count.
        pa = '0; pb = '0;
        for (int k = 0; k < 5 * (W + 1); k++) begin
            start = 1'b1; a = W'($urandom); b = W'($urandom);
            if (k % (W + 1) == 0) begin pa = a; pb = b; end
            tick();
            if (k % (W + 1) == W) begin
                check("b2b.done", 32'(done), 32'd1);
                check_result("b2b", pa, pb);
            end else begin
                check("b2b.done_lo", 32'(done), 32'd0);
            end
        end
        start = 1'b0;
        tick();
        check("b2b.idle_done", 32'(done), 32'd0);

        // Abort at RUN cycle 4 after a nonzero result is on the outputs.
        run_op("pre_abort", 8'h03, 8'h05, 1'b0);
        start = 1'b1; a = 8'h44; b = 8'h11;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("abort.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.diff", 32'(diff), 32'd0);
        check("abort.flags", {29'd0, borrow, ovf, zero}, 32'd0);
        for (int i = 0; i < W; i++) begin
            tick();
            check("abort.no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        hold_diff = '0; hold_borrow = 1'b0; hold_ovf = 1'b0; hold_zero = 1'b0;
        tick();
        run_op("post_abort", 8'h44, 8'h11, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
